// File: rtl/eb_pkg.sv
// Shared types for the elastic-buffer family of stream register slices.
package eb_pkg;

    typedef enum logic {
        EB_PASS = 1'b0,
        EB_SKID = 1'b1
    } eb_skid_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; used for stall and occupancy monitors.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rdy_skid_buffer.sv
// Ready-path register slice: upstream_rdy comes straight from the state flop and a
// one-entry skid register absorbs the beat accepted while downstream stalls.
module rdy_skid_buffer
    import eb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  upstream_vld,
    output logic                  upstream_rdy,
    input  logic [DATA_WIDTH-1:0] upstream_data,
    output logic                  downstream_vld,
    input  logic                  downstream_rdy,
    output logic [DATA_WIDTH-1:0] downstream_data,
    output logic [CNT_WIDTH-1:0]  stall_cnt,
    input  logic                  stall_clr
);

    eb_skid_state_t        state;
    logic [DATA_WIDTH-1:0] skid_data;

    // In PASS the producer already saw rdy=1, so a beat the consumer refuses
    // must be parked; in SKID nothing new can arrive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EB_PASS;
            skid_data <= '0;
        end else if (state == EB_PASS) begin
            if (upstream_vld && !downstream_rdy) begin
                skid_data <= upstream_data;
                state     <= EB_SKID;
            end
        end else begin
            if (downstream_rdy) begin
                state <= EB_PASS;
            end
        end
    end

    assign upstream_rdy    = (state == EB_PASS);
    assign downstream_vld  = (state == EB_SKID) | upstream_vld;
    assign downstream_data = (state == EB_SKID) ? skid_data : upstream_data;

    sat_counter #(.W(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (~upstream_rdy),
        .clr   (stall_clr),
        .cnt   (stall_cnt)
    );

endmodule

// File: tb/tb_rdy_skid_buffer.sv
// Directed and scoreboarded checks for rdy_skid_buffer, plus a 2-bit counter instance.
module tb_rdy_skid_buffer;

    logic        clk;
    logic        rst_n;
    logic        upstream_vld;
    logic        upstream_rdy;
    logic [7:0]  upstream_data;
    logic        downstream_vld;
    logic        downstream_rdy;
    logic [7:0]  downstream_data;
    logic [15:0] stall_cnt;
    logic        stall_clr;

    logic        upstream_rdy2;
    logic        downstream_vld2;
    logic [7:0]  downstream_data2;
    logic [1:0]  stall_cnt2;

    int n_chk  = 0;
    int n_pass = 0;

    rdy_skid_buffer #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .upstream_vld    (upstream_vld),
        .upstream_rdy    (upstream_rdy),
        .upstream_data   (upstream_data),
        .downstream_vld  (downstream_vld),
        .downstream_rdy  (downstream_rdy),
        .downstream_data (downstream_data),
        .stall_cnt       (stall_cnt),
        .stall_clr       (stall_clr)
    );

    rdy_skid_buffer #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dut2 (
        .clk             (clk),
        .rst_n           (rst_n),
        .upstream_vld    (upstream_vld),
        .upstream_rdy    (upstream_rdy2),
        .upstream_data   (upstream_data),
        .downstream_vld  (downstream_vld2),
        .downstream_rdy  (downstream_rdy),
        .downstream_data (downstream_data2),
        .stall_cnt       (stall_cnt2),
        .stall_clr       (stall_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] exp_d;
        logic [7:0] held_d;
        logic       held;
        logic       up_acc;
        logic       dn_acc;
        int         drops;

        rst_n          = 1'b1;
        upstream_vld   = 1'b0;
        upstream_data  = 8'h00;
        downstream_rdy = 1'b1;
        stall_clr      = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_up_rdy", 32'(upstream_rdy), 32'd1);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_dn_vld", 32'(downstream_vld), 32'd0);
        upstream_vld  = 1'b1;
        upstream_data = 8'h77;
        #1;
        chk("rst_pass_vld", 32'(downstream_vld), 32'd1);
        chk("rst_pass_data", 32'(downstream_data), 32'h77);
        upstream_vld = 1'b0;
        smp();
        rst_n = 1'b1;

        // Streaming with consumer always ready: one beat per clock, no stalls.
        for (int i = 1; i <= 16; i++) begin
            cyc();
            upstream_vld   = 1'b1;
            upstream_data  = 8'(i);
            downstream_rdy = 1'b1;
            smp();
            chk("stream_vld", 32'(downstream_vld), 32'd1);
            chk("stream_data", 32'(downstream_data), 32'(i));
            chk("stream_up_rdy", 32'(upstream_rdy), 32'd1);
        end
        cyc();
        upstream_vld = 1'b0;
        smp();
        chk("stream_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("stream_idle_vld", 32'(downstream_vld), 32'd0);

        // Single capture of 0xA5, two held cycles, then consume.
        cyc();
        upstream_vld   = 1'b1;
        upstream_data  = 8'hA5;
        downstream_rdy = 1'b0;
        smp();
        chk("cap_up_rdy", 32'(upstream_rdy), 32'd1);
        chk("cap_pass_data", 32'(downstream_data), 32'hA5);
        for (int k = 0; k < 2; k++) begin
            cyc();
            upstream_vld  = 1'b0;
            upstream_data = 8'hFF;
            smp();
            chk("skid_up_rdy", 32'(upstream_rdy), 32'd0);
            chk("skid_vld", 32'(downstream_vld), 32'd1);
            chk("skid_data", 32'(downstream_data), 32'hA5);
        end
        cyc();
        downstream_rdy = 1'b1;
        smp();
        chk("consume_data", 32'(downstream_data), 32'hA5);
        chk("consume_up_rdy", 32'(upstream_rdy), 32'd0);
        cyc();
        smp();
        chk("after_up_rdy", 32'(upstream_rdy), 32'd1);
        chk("after_no_dup", 32'(downstream_vld), 32'd0);
        chk("after_stall_cnt", 32'(stall_cnt), 32'd3);
        cyc();
        stall_clr = 1'b1;
        cyc();
        stall_clr = 1'b0;
        smp();
        chk("clr_cnt", 32'(stall_cnt), 32'd0);
        chk("clr_cnt2", 32'(stall_cnt2), 32'd0);

        // Long stall: 10 SKID cycles, 16-bit counts to 10, 2-bit saturates at 3.
        cyc();
        upstream_vld   = 1'b1;
        upstream_data  = 8'h5A;
        downstream_rdy = 1'b0;
        smp();
        for (int k = 1; k <= 10; k++) begin
            cyc();
            upstream_vld  = 1'b0;
            upstream_data = 8'(k);
            smp();
            chk("hold_data", 32'(downstream_data), 32'h5A);
            if (k == 6) begin
                chk("stall5", 32'(stall_cnt), 32'd5);
                chk("stall5_sat", 32'(stall_cnt2), 32'd3);
            end
        end
        cyc();
        downstream_rdy = 1'b1;
        smp();
        chk("stall10", 32'(stall_cnt), 32'd10);
        chk("stall10_sat", 32'(stall_cnt2), 32'd3);
        chk("stall10_data2", 32'(downstream_data2), 32'h5A);
        cyc();
        stall_clr = 1'b1;
        smp();
        chk("pre_clr_cnt", 32'(stall_cnt), 32'd11);
        cyc();
        stall_clr = 1'b0;
        smp();
        chk("post_clr_cnt", 32'(stall_cnt), 32'd0);
        chk("post_clr_cnt2", 32'(stall_cnt2), 32'd0);

        // Async reset while 0x3C sits in the skid register.
        cyc();
        upstream_vld   = 1'b1;
        upstream_data  = 8'h3C;
        downstream_rdy = 1'b0;
        cyc();
        upstream_vld  = 1'b0;
        upstream_data = 8'h00;
        #1;
        chk("r5_in_skid", 32'(upstream_rdy), 32'd0);
        chk("r5_skid_data", 32'(downstream_data), 32'h3C);
        rst_n = 1'b0;
        #1;
        chk("r5_up_rdy", 32'(upstream_rdy), 32'd1);
        chk("r5_dn_vld", 32'(downstream_vld), 32'd0);
        chk("r5_cnt", 32'(stall_cnt), 32'd0);
        upstream_vld  = 1'b1;
        upstream_data = 8'h11;
        #1;
        chk("r5_follow_vld", 32'(downstream_vld), 32'd1);
        chk("r5_follow_data", 32'(downstream_data), 32'h11);
        smp();
        rst_n          = 1'b1;
        upstream_vld   = 1'b0;
        downstream_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            smp();
            chk("r5_no_3c", 32'(downstream_vld), 32'd0);
        end

        // Random traffic against an in-order scoreboard.
        held   = 1'b0;
        held_d = 8'h00;
        up_acc = 1'b0;
        drops  = 0;
        for (int c = 0; c < 3000; c++) begin
            cyc();
            if (!upstream_vld || up_acc) begin
                upstream_vld  = ($urandom_range(0, 9) < 7);
                upstream_data = 8'($urandom);
            end
            downstream_rdy = ($urandom_range(0, 9) < 6);
            smp();
            if (held) begin
                chk("rnd_hold_vld", 32'(downstream_vld), 32'd1);
                chk("rnd_hold_data", 32'(downstream_data), 32'(held_d));
            end
            up_acc = upstream_vld && upstream_rdy;
            dn_acc = downstream_vld && downstream_rdy;
            if (up_acc) q.push_back(upstream_data);
            if (dn_acc) begin
                if (q.size() == 0) begin
                    chk("rnd_spurious", 32'(downstream_data), 32'hDEAD);
                end else begin
                    exp_d = q.pop_front();
                    chk("rnd_data", 32'(downstream_data), 32'(exp_d));
                end
            end
            if (q.size() > 1) drops++;
            held   = downstream_vld && !downstream_rdy;
            held_d = downstream_data;
        end
        chk("rnd_occupancy", 32'(drops), 32'd0);
        cyc();
        upstream_vld   = 1'b0;
        downstream_rdy = 1'b1;
        smp();
        if (downstream_vld && q.size() != 0) begin
            exp_d = q.pop_front();
            chk("drain_data", 32'(downstream_data), 32'(exp_d));
        end
        cyc();
        smp();
        chk("drain_empty", 32'(q.size()), 32'd0);
        chk("drain_idle", 32'(downstream_vld), 32'd0);
        chk("drain_up_rdy", 32'(upstream_rdy2), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
